// File: rtl/fulladder_4b.sv
// fulladder_4b: 4-bit ripple-carry adder built from four 1-bit full-adder
// cells, with sum, carry-out and signed overflow registered on the clock.
// One-cycle latency, one addition per clock, no enable or handshake.

// Single 1-bit full-adder cell; one instance per bit of the ripple chain.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module fulladder_4b (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry,
    output logic       overflow
);
    typedef struct packed {
        logic       carry;
        logic       overflow;
        logic [3:0] sum;
    } res_t;

    // c[i] is the carry into bit i; c[4] is the carry out of the top bit.
    logic [4:0] c;
    logic [3:0] s;
    res_t       res_next;
    res_t       res_q;

    assign c[0] = cin;

    // Ripple chain: each cell's carry-out feeds the next cell's carry-in.
    fa_cell u_cell [3:0] (
        .a  (a),
        .b  (b),
        .ci (c[3:0]),
        .s  (s),
        .co (c[4:1])
    );

    // Signed overflow: the carry into the sign bit disagrees with the carry out of it.
    always_comb begin
        res_next          = '0;
        res_next.sum      = s;
        res_next.carry    = c[4];
        res_next.overflow = c[3] ^ c[4];
    end

    // Result register; reset clears all outputs immediately, without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) res_q <= '0;
        else     res_q <= res_next;
    end

    assign sum      = res_q.sum;
    assign carry    = res_q.carry;
    assign overflow = res_q.overflow;
endmodule

// File: tb/tb_fulladder_4b.sv
// Directed and exhaustive bench for fulladder_4b. Inputs change 1ns after a
// rising edge; outputs are sampled 1ns after the edge that captured them.
module tb_fulladder_4b;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] sum;
    logic       carry, overflow;

    int ncmp  = 0;
    int nfail = 0;

    fulladder_4b dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] s_exp,
                         input logic c_exp, input logic o_exp);
        ncmp++;
        assert (sum === s_exp) else begin
            nfail++;
            $error("FAIL %s sum: got %h want %h", tag, sum, s_exp);
        end
        ncmp++;
        assert (carry === c_exp) else begin
            nfail++;
            $error("FAIL %s carry: got %b want %b", tag, carry, c_exp);
        end
        ncmp++;
        assert (overflow === o_exp) else begin
            nfail++;
            $error("FAIL %s overflow: got %b want %b", tag, overflow, o_exp);
        end
    endtask

    // Apply one vector, clock it in, and compare with hand-computed values.
    task automatic step(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic vc, input logic [3:0] s_exp,
                        input logic c_exp, input logic o_exp);
        a = va; b = vb; cin = vc;
        @(posedge clk); #1;
        check(tag, s_exp, c_exp, o_exp);
    endtask

    // Apply one vector and compare against an arithmetic reference model.
    task automatic step_model(input string tag, input logic [3:0] va,
                              input logic [3:0] vb, input logic vc);
        logic [4:0] tot;
        logic       ov;
        tot = {1'b0, va} + {1'b0, vb} + {4'b0, vc};
        ov  = (va[3] == vb[3]) && (tot[3] != va[3]);
        a = va; b = vb; cin = vc;
        @(posedge clk); #1;
        check(tag, tot[3:0], tot[4], ov);
    endtask

    initial begin
        rst = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b1;
        #2;
        check("reset_async", 4'h0, 1'b0, 1'b0);
        // Edges while held in reset must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_hold", 4'h0, 1'b0, 1'b0);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release", 4'hF, 1'b1, 1'b0);

        step("zero",        4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        step("cin_only",    4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0);
        step("ripple_cin",  4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0);
        step("ripple_b",    4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        step("ovf_pos",     4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        step("ovf_neg",     4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
        step("ovf_cin",     4'h5, 4'h3, 1'b1, 4'h9, 1'b0, 1'b1);
        step("max",         4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
        step("neg_no_ovf",  4'hC, 4'h6, 1'b0, 4'h2, 1'b1, 1'b0);
        step("mid",         4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step_model("exhaustive", v[8:5], v[4:1], v[0]);
        end

        for (int i = 0; i < 16; i++)
            step_model("random", 4'($urandom), 4'($urandom), 1'($urandom));

        // Asynchronous reset between edges while results are flowing.
        step("pre_rst", 4'h6, 4'h7, 1'b0, 4'hD, 1'b0, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("mid_rst", 4'h0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        step("post_rst", 4'h9, 4'h9, 1'b1, 4'h3, 1'b1, 1'b1);
        step("post_rst2", 4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
